// File: rtl/cpu_pkg.sv
// Shared CPU definitions: reset/exception constants, the canonical NOP and the
// redirect-source encoding used by the fetch stage and the hazard unit.
package cpu_pkg;

   localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;  // sll $0,$0,0
   localparam logic [31:0] RESET_PC   = 32'h0000_0000;
   localparam logic [31:0] EXC_VECTOR = 32'h0000_0180;

   // Which control-flow source wins this cycle, highest priority first
   typedef enum logic [1:0] {
      RD_NONE = 2'd0,
      RD_EXC  = 2'd1,
      RD_BR   = 2'd2,
      RD_JMP  = 2'd3
   } redirect_e;

   // Force a byte address onto a word boundary
   function automatic logic [31:0] word_align(input logic [31:0] a);
      return a & ~32'h0000_0003;
   endfunction

endpackage

// File: rtl/if_id_reg.sv
// Generic pipeline register between two stages. A bubble clears the valid bit
// and replaces the instruction with a NOP while keeping the PC fields, so a
// squashed slot still carries the last meaningful PC for debug.
module if_id_reg
   import cpu_pkg::*;
#(
   parameter logic [31:0] NOP_WORD = cpu_pkg::NOP_INSTR
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall_i,   // hold every field
   input  logic        bubble_i,  // insert a bubble; beats stall_i
   input  logic [31:0] instr_i,
   input  logic [31:0] pc_i,
   input  logic [31:0] pc4_i,
   output logic        valid_o,
   output logic [31:0] instr_o,
   output logic [31:0] pc_o,
   output logic [31:0] pc4_o
);

   logic        valid_q, valid_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] pc_q,    pc_d;
   logic [31:0] pc4_q,   pc4_d;

   // Next-state select: bubble, hold, or capture the incoming slot
   always_comb begin
      valid_d = valid_q;
      instr_d = instr_q;
      pc_d    = pc_q;
      pc4_d   = pc4_q;
      if (bubble_i) begin
         valid_d = 1'b0;
         instr_d = NOP_WORD;
      end else if (!stall_i) begin
         valid_d = 1'b1;
         instr_d = instr_i;
         pc_d    = pc_i;
         pc4_d   = pc4_i;
      end
   end

   // Slot register with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         instr_q <= NOP_WORD;
         pc_q    <= 32'h0;
         pc4_q   <= 32'h0;
      end else begin
         valid_q <= valid_d;
         instr_q <= instr_d;
         pc_q    <= pc_d;
         pc4_q   <= pc4_d;
      end
   end

   assign valid_o = valid_q;
   assign instr_o = instr_q;
   assign pc_o    = pc_q;
   assign pc4_o   = pc4_q;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, drives the instruction memory address
// straight from the PC flop, and fills the IF/ID register. Redirects
// (exception > branch > jump) beat stall so a wrong-path word is never kept.
// The memory is combinational and always ready, so there is no handshake:
// imem_data is consumed in the same cycle imem_addr is presented.
module if_stage
   import cpu_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = cpu_pkg::RESET_PC,
   parameter logic [31:0] EXC_VECTOR = cpu_pkg::EXC_VECTOR,
   parameter logic [31:0] NOP_INSTR  = cpu_pkg::NOP_INSTR
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_data,
   input  logic        stall,
   input  logic        flush,
   input  logic        exc_req,
   input  logic        br_taken,
   input  logic [31:0] br_target,
   input  logic        jmp,
   input  logic [31:0] jmp_target,
   output logic        if_id_valid,
   output logic [31:0] if_id_instr,
   output logic [31:0] if_id_pc,
   output logic [31:0] if_id_pc4,
   output logic [31:0] fetch_cnt
);

   redirect_e   rd_src;
   logic        redirect;
   logic        squash;
   logic        deliver;
   logic [31:0] pc_q, pc_d;
   logic [31:0] pc_plus4;
   logic [31:0] cnt_q, cnt_d;

   assign pc_plus4 = pc_q + 32'd4;

   // Priority encode the redirect source
   always_comb begin
      rd_src = RD_NONE;
      if (exc_req)       rd_src = RD_EXC;
      else if (br_taken) rd_src = RD_BR;
      else if (jmp)      rd_src = RD_JMP;
   end

   assign redirect = (rd_src != RD_NONE);
   assign squash   = redirect | flush;
   // A real instruction enters IF/ID only when nothing squashes or holds it
   assign deliver  = !squash && !stall;

   // Next PC: redirect target, hold on stall, else sequential
   always_comb begin
      pc_d = pc_plus4;
      unique case (rd_src)
         RD_EXC:  pc_d = word_align(EXC_VECTOR);
         RD_BR:   pc_d = word_align(br_target);
         RD_JMP:  pc_d = word_align(jmp_target);
         default: if (stall) pc_d = pc_q;
      endcase
   end

   // Delivered-instruction counter, wraps naturally at 2^32
   always_comb begin
      cnt_d = cnt_q;
      if (deliver) cnt_d = cnt_q + 32'd1;
   end

   // PC and counter registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pc_q  <= word_align(RESET_PC);
         cnt_q <= 32'h0;
      end else begin
         pc_q  <= pc_d;
         cnt_q <= cnt_d;
      end
   end

   if_id_reg #(.NOP_WORD(NOP_INSTR)) u_if_id (
      .clk      (clk),
      .rst_n    (rst_n),
      .stall_i  (stall),
      .bubble_i (squash),
      .instr_i  (imem_data),
      .pc_i     (pc_q),
      .pc4_i    (pc_plus4),
      .valid_o  (if_id_valid),
      .instr_o  (if_id_instr),
      .pc_o     (if_id_pc),
      .pc4_o    (if_id_pc4)
   );

   assign imem_addr = pc_q;
   assign fetch_cnt = cnt_q;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: a behavioural instruction memory plus
// hand-computed expectations after each rising edge.
module tb_if_stage;

   logic        clk;
   logic        rst_n;
   logic [31:0] imem_addr;
   logic [31:0] imem_data;
   logic        stall;
   logic        flush;
   logic        exc_req;
   logic        br_taken;
   logic [31:0] br_target;
   logic        jmp;
   logic [31:0] jmp_target;
   logic        if_id_valid;
   logic [31:0] if_id_instr;
   logic [31:0] if_id_pc;
   logic [31:0] if_id_pc4;
   logic [31:0] fetch_cnt;

   int checks;
   int failures;

   if_stage dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .imem_addr   (imem_addr),
      .imem_data   (imem_data),
      .stall       (stall),
      .flush       (flush),
      .exc_req     (exc_req),
      .br_taken    (br_taken),
      .br_target   (br_target),
      .jmp         (jmp),
      .jmp_target  (jmp_target),
      .if_id_valid (if_id_valid),
      .if_id_instr (if_id_instr),
      .if_id_pc    (if_id_pc),
      .if_id_pc4   (if_id_pc4),
      .fetch_cnt   (fetch_cnt)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // memory contents: distinct, nonzero word per address
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {~a[15:0], a[15:0]} ^ 32'h0BAD_0000;
   endfunction

   assign imem_data = mem_word(imem_addr);

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // advance one rising edge; sample and drive #1 after it
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      stall = 0; flush = 0; exc_req = 0; br_taken = 0; jmp = 0;
      br_target = 32'h0; jmp_target = 32'h0;
   endtask

   task automatic check_slot(input string tag, input logic [31:0] pc, input logic v,
                             input logic [31:0] ipc, input logic [31:0] cnt);
      check({tag, ".pc"},    imem_addr, pc);
      check({tag, ".valid"}, {31'h0, if_id_valid}, {31'h0, v});
      check({tag, ".instr"}, if_id_instr, v ? mem_word(ipc) : 32'h0);
      check({tag, ".ifpc"},  if_id_pc, ipc);
      check({tag, ".pc4"},   if_id_pc4, ipc + 32'd4);
      check({tag, ".cnt"},   fetch_cnt, cnt);
   endtask

   initial begin
      checks = 0;
      failures = 0;
      idle_inputs();
      rst_n = 0;

      // 1. reset and sequential fetch
      step(); step(); step();
      check("rst.pc", imem_addr, 32'h0);
      check("rst.valid", {31'h0, if_id_valid}, 32'h0);
      check("rst.instr", if_id_instr, 32'h0);
      check("rst.ifpc", if_id_pc, 32'h0);
      check("rst.pc4", if_id_pc4, 32'h0);
      check("rst.cnt", fetch_cnt, 32'h0);
      rst_n = 1;
      step(); check_slot("seq1", 32'h4, 1, 32'h0, 1);
      step(); check_slot("seq2", 32'h8, 1, 32'h4, 2);
      step(); check_slot("seq3", 32'hC, 1, 32'h8, 3);
      step(); check_slot("seq4", 32'h10, 1, 32'hC, 4);

      // 2. stall two cycles at 0x10
      stall = 1;
      step(); check_slot("stall1", 32'h10, 1, 32'hC, 4);
      step(); check_slot("stall2", 32'h10, 1, 32'hC, 4);
      stall = 0;
      step(); check_slot("resume", 32'h14, 1, 32'h10, 5);

      // 3. branch beats stall, target aligned down
      stall = 1; br_taken = 1; br_target = 32'h43;
      step(); check_slot("br_stall", 32'h40, 0, 32'h10, 5);
      idle_inputs();

      // 4. exception beats branch and jump
      exc_req = 1; br_taken = 1; br_target = 32'h43; jmp = 1; jmp_target = 32'h99;
      step(); check_slot("exc", 32'h180, 0, 32'h10, 5);
      idle_inputs();
      step(); check_slot("exc_next", 32'h184, 1, 32'h180, 6);

      // 5. flush alone at 0x20, then flush with stall
      jmp = 1; jmp_target = 32'h20;
      step(); check_slot("jmp20", 32'h20, 0, 32'h180, 6);
      idle_inputs(); flush = 1;
      step(); check_slot("flush", 32'h24, 0, 32'h180, 6);
      flush = 0;
      step(); check_slot("after_flush", 32'h28, 1, 32'h24, 7);
      flush = 1; stall = 1;
      step(); check_slot("flush_stall", 32'h28, 0, 32'h24, 7);
      idle_inputs();
      step(); check_slot("after_fs", 32'h2C, 1, 32'h28, 8);

      // 6. PC wrap at top of address space (jump target misaligned on purpose)
      jmp = 1; jmp_target = 32'hFFFF_FFFE;
      step(); check_slot("jmp_top", 32'hFFFF_FFFC, 0, 32'h28, 8);
      idle_inputs();
      step(); check_slot("wrap", 32'h0, 1, 32'hFFFF_FFFC, 9);
      step(); check_slot("wrap_next", 32'h4, 1, 32'h0, 10);

      // reset overrides an in-flight redirect and stall
      stall = 1; br_taken = 1; br_target = 32'h400; rst_n = 0;
      step();
      check("rst2.pc", imem_addr, 32'h0);
      check("rst2.valid", {31'h0, if_id_valid}, 32'h0);
      check("rst2.instr", if_id_instr, 32'h0);
      check("rst2.ifpc", if_id_pc, 32'h0);
      check("rst2.cnt", fetch_cnt, 32'h0);
      idle_inputs(); rst_n = 1;
      step(); check_slot("rst2_run", 32'h4, 1, 32'h0, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
